alu_operand_loader: RTL and testbench

Front-end operand sequencer for the 4-bit board ALU. It turns a single raw push-button and four data switches into three captured fields: operand A, operand B and the 3-bit opcode. Each field is captured on a debounced button press. The block sits directly upstream of the ALU, drives its A/B/op inputs from registers, and emits a one-cycle `valid` pulse when a complete operation has been entered.

---
 rtl/alu_pkg.sv | 14 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/alu_operand_loader.sv | 90 +++++++++
 tb/tb_alu_operand_loader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the board ALU and its operand front end.
package alu_pkg;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned OP_W  = 3;

    typedef enum logic [1:0] {
        ST_A   = 2'b00,
        ST_B   = 2'b01,
        ST_OP  = 2'b10,
        ST_RUN = 2'b11
    } stage_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stable-count debouncer and
// a one-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic            db;
    logic            db_q;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_q <= db;
            // Any sample agreeing with the current level restarts the count.
            if (s2 != db) begin
                if (cnt == CNT_MAX) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = db;
    assign press = db & ~db_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand sequencer for the board ALU: each debounced press captures A, then B,
// then the opcode (with a valid pulse), then a spare press returns to A.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DB_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic [ALU_W-1:0] sw,
    output logic [ALU_W-1:0] a,
    output logic [ALU_W-1:0] b,
    output logic [OP_W-1:0]  op,
    output logic             valid,
    output logic [1:0]       stage
);

    logic press;

    stage_e           state_q, state_d;
    logic [ALU_W-1:0] a_q, a_d;
    logic [ALU_W-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             valid_q, valid_d;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .level(),
        .press(press)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = 1'b0;
        if (press) begin
            unique case (state_q)
                ST_A: begin
                    a_d     = sw;
                    state_d = ST_B;
                end
                ST_B: begin
                    b_d     = sw;
                    state_d = ST_OP;
                end
                ST_OP: begin
                    op_d    = sw[OP_W-1:0];
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    state_d = ST_A;
                end
                default: state_d = ST_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign op    = op_q;
    assign valid = valid_q;
    assign stage = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window (4 cycles).
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [3:0] sw;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       valid;
    logic [1:0] stage;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_stage;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [1:0] stage;
        logic       valid;
    } vec_t;

    vec_t vecs[5];

    alu_operand_loader #(
        .DB_CYCLES(4),
        .DB_W     (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .sw   (sw),
        .a    (a),
        .b    (b),
        .op   (op),
        .valid(valid),
        .stage(stage)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Press with sw held; capture must land exactly on the 7th edge after btn rises.
    task automatic press_vec(input vec_t v);
        sw  = v.sw;
        btn = 1'b1;
        repeat (6) step();
        check("pre_capture_stage", 8'(stage), 8'(exp_stage));
        check("pre_capture_valid", 8'(valid), 8'(0));
        step();
        check("cap_a", 8'(a), 8'(v.a));
        check("cap_b", 8'(b), 8'(v.b));
        check("cap_op", 8'(op), 8'(v.op));
        check("cap_stage", 8'(stage), 8'(v.stage));
        check("cap_valid", 8'(valid), 8'(v.valid));
        step();
        check("post_valid", 8'(valid), 8'(0));
        check("post_stage", 8'(stage), 8'(v.stage));
        btn = 1'b0;
        repeat (10) step();
        exp_stage = v.stage;
    endtask

    initial begin
        vecs[0] = '{sw: 4'h5, a: 4'h5, b: 4'h0, op: 3'h0, stage: 2'b01, valid: 1'b0};
        vecs[1] = '{sw: 4'hA, a: 4'h5, b: 4'hA, op: 3'h0, stage: 2'b10, valid: 1'b0};
        vecs[2] = '{sw: 4'hE, a: 4'h5, b: 4'hA, op: 3'h6, stage: 2'b11, valid: 1'b1};
        vecs[3] = '{sw: 4'h7, a: 4'h5, b: 4'hA, op: 3'h6, stage: 2'b00, valid: 1'b0};
        vecs[4] = '{sw: 4'h3, a: 4'h3, b: 4'hA, op: 3'h6, stage: 2'b01, valid: 1'b0};

        // Reset with random inputs
        rst = 1'b1;
        btn = 1'($urandom);
        sw  = 4'($urandom);
        step();
        check("rst_a", 8'(a), 8'(0));
        check("rst_b", 8'(b), 8'(0));
        check("rst_op", 8'(op), 8'(0));
        check("rst_valid", 8'(valid), 8'(0));
        check("rst_stage", 8'(stage), 8'(0));
        btn = 1'($urandom);
        sw  = 4'($urandom);
        step();
        step();
        check("rst_hold_stage", 8'(stage), 8'(0));
        rst = 1'b0;
        btn = 1'b0;
        repeat (10) step();
        exp_stage = 2'b00;

        // Full entry, wrap, and first capture after wrap
        for (int i = 0; i < 5; i++) begin
            press_vec(vecs[i]);
        end

        // Bounce: high 3, low 1, then steady high; count restarts from final rise
        sw  = 4'h9;
        btn = 1'b1;
        repeat (3) step();
        btn = 1'b0;
        step();
        btn = 1'b1;
        repeat (6) step();
        check("bounce_no_early", 8'(stage), 8'(1));
        step();
        check("bounce_stage", 8'(stage), 8'(2));
        check("bounce_b", 8'(b), 8'h9);
        check("bounce_a", 8'(a), 8'h3);
        repeat (20) step();
        check("bounce_single", 8'(stage), 8'(2));
        btn = 1'b0;
        repeat (10) step();

        // Reset in S_OP landing on the same edge as a press: reset wins
        sw  = 4'hC;
        btn = 1'b1;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_a", 8'(a), 8'(0));
        check("midrst_b", 8'(b), 8'(0));
        check("midrst_op", 8'(op), 8'(0));
        check("midrst_valid", 8'(valid), 8'(0));
        check("midrst_stage", 8'(stage), 8'(0));
        repeat (6) step();
        check("midrst_no_early", 8'(stage), 8'(0));
        step();
        check("midrst_press_stage", 8'(stage), 8'(1));
        check("midrst_press_a", 8'(a), 8'hC);

        // Held button gives one press only; short release then a new press
        repeat (50) step();
        check("held_stage", 8'(stage), 8'(1));
        check("held_a", 8'(a), 8'hC);
        btn = 1'b0;
        repeat (6) step();
        sw  = 4'h6;
        btn = 1'b1;
        repeat (6) step();
        check("repress_no_early", 8'(stage), 8'(1));
        step();
        check("repress_stage", 8'(stage), 8'(2));
        check("repress_b", 8'(b), 8'h6);
        check("repress_a", 8'(a), 8'hC);
        check("repress_valid", 8'(valid), 8'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
